// File: rtl/calc_serial_pkg.sv
// Shared types for the calculator result serialiser.
// Frame state encoding and idle line level.
package calc_serial_pkg;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/serial_result_tx_rise_detect.sv
// Rising-edge detector for a slow clock sampled in the Clk domain.
// Shared by the divider consumers.
module rise_detect (
    input  logic Clk,
    input  logic Reset,
    input  logic In,
    output logic Pulse
);

    logic prev_q;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= In;
        end
    end

    assign Pulse = In & ~prev_q;

endmodule

// File: rtl/serial_result_tx.sv
// UART-style serialiser for one calculator result word.
// One bit period per DivClk period; divider enabled only mid-frame.
module serial_result_tx
    import calc_serial_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PARITY_EN = 1,
    parameter int STOP_BITS = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             DivClk,
    input  logic [WIDTH-1:0] Din,
    input  logic             Valid,
    output logic             Ready,
    output logic             DivEnable,
    output logic             TxOut,
    output logic             Busy,
    output logic             Done
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT  = CW'(WIDTH - 1);
    localparam logic [CW-1:0] LAST_STOP = CW'(STOP_BITS - 1);

    tx_state_t        state_q;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_nxt;
    logic [CW-1:0]    bitcnt_q;
    logic [CW-1:0]    stopcnt_q;
    logic             par_q;
    logic             tx_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             den_q;
    logic             tick;

    rise_detect u_rise (
        .Clk   (Clk),
        .Reset (Reset),
        .In    (DivClk),
        .Pulse (tick)
    );

    assign shift_nxt = shift_q >> 1;

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= TX_IDLE;
            shift_q   <= '0;
            bitcnt_q  <= '0;
            stopcnt_q <= '0;
            par_q     <= 1'b0;
            tx_q      <= TX_IDLE_LEVEL;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            den_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                TX_IDLE: begin
                    if (Valid && ready_q) begin
                        state_q <= TX_START;
                        shift_q <= Din;
                        par_q   <= ^Din;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        den_q   <= 1'b1;
                        ready_q <= 1'b0;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        state_q  <= TX_DATA;
                        tx_q     <= shift_q[0];
                        bitcnt_q <= '0;
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        if (bitcnt_q == LAST_BIT) begin
                            if (PARITY_EN != 0) begin
                                state_q <= TX_PARITY;
                                tx_q    <= par_q;
                            end else begin
                                state_q   <= TX_STOP;
                                tx_q      <= TX_IDLE_LEVEL;
                                stopcnt_q <= '0;
                            end
                        end else begin
                            bitcnt_q <= bitcnt_q + 1'b1;
                            shift_q  <= shift_nxt;
                            tx_q     <= shift_nxt[0];
                        end
                    end
                end
                TX_PARITY: begin
                    if (tick) begin
                        state_q   <= TX_STOP;
                        tx_q      <= TX_IDLE_LEVEL;
                        stopcnt_q <= '0;
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        if (stopcnt_q == LAST_STOP) begin
                            state_q <= TX_IDLE;
                            done_q  <= 1'b1;
                            den_q   <= 1'b0;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                        end else begin
                            stopcnt_q <= stopcnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= TX_IDLE;
                    tx_q    <= TX_IDLE_LEVEL;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    den_q   <= 1'b0;
                end
            endcase
        end
    end

    assign Ready     = ready_q;
    assign DivEnable = den_q;
    assign TxOut     = tx_q;
    assign Busy      = busy_q;
    assign Done      = done_q;

endmodule

// File: tb/tb_serial_result_tx.sv
// Bench for serial_result_tx: a mid-bit sampling receiver checks
// each frame against bit lists built from the word.
module tb_serial_result_tx;

    localparam int W  = 8;
    localparam int PE = 1;
    localparam int SB = 1;

    logic         Clk    = 1'b0;
    logic         Reset  = 1'b0;
    logic         DivClk = 1'b0;
    logic         Valid  = 1'b0;
    logic [W-1:0] Din    = '0;
    logic         Ready;
    logic         DivEnable;
    logic         TxOut;
    logic         Busy;
    logic         Done;

    int n_pass   = 0;
    int n_chk    = 0;
    int done_cnt = 0;
    int per      = 8;
    int dcnt     = 0;
    bit dforce   = 0;
    bit rose     = 0;
    bit fell     = 0;
    bit hold     = 0;

    always #5 Clk = ~Clk;

    serial_result_tx #(
        .WIDTH     (W),
        .PARITY_EN (PE),
        .STOP_BITS (SB)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .DivClk    (DivClk),
        .Din       (Din),
        .Valid     (Valid),
        .Ready     (Ready),
        .DivEnable (DivEnable),
        .TxOut     (TxOut),
        .Busy      (Busy),
        .Done      (Done)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic timeout(input string tag);
        n_chk++;
        $error("FAIL %s: wait bound expired", tag);
    endtask

    // One Clk step; the bench's divided clock advances right after the edge.
    task automatic step();
        logic nv;
        @(posedge Clk);
        #1;
        rose = 0;
        fell = 0;
        if (dforce) begin
            rose   = ~DivClk;
            DivClk = 1'b1;
        end else begin
            dcnt   = (dcnt + 1) % per;
            nv     = (dcnt >= per / 2);
            rose   = nv & ~DivClk;
            fell   = ~nv & DivClk;
            DivClk = nv;
        end
        if (Done === 1'b1) done_cnt++;
    endtask

    task automatic set_period(input int p);
        per    = p;
        dcnt   = 0;
        DivClk = 1'b0;
    endtask

    task automatic start_frame(input logic [W-1:0] w);
        Din      = w;
        Valid    = 1'b1;
        done_cnt = 0;
        step();
        if (!hold) Valid = 1'b0;
    endtask

    // Receiver: line is sampled at every DivClk fall after the first rise.
    task automatic rx_frame(input logic [W-1:0] w, input int abort_at,
                            input int inject_at);
        bit q[$];
        int t;
        q = {};
        for (int i = 0; i < W; i++) q.push_back(w[i]);
        if (PE != 0) q.push_back(^w);
        for (int i = 0; i < SB; i++) q.push_back(1'b1);

        chk("start_tx", TxOut, 1'b0);
        chk("start_busy", Busy, 1'b1);
        chk("start_den", DivEnable, 1'b1);
        chk("start_ready", Ready, 1'b0);

        t = 0;
        while (!rose && t < 4 * per) begin
            step();
            t++;
        end
        if (!rose) timeout("first_rise");

        for (int i = 0; i < q.size(); i++) begin
            t = 0;
            do begin
                step();
                t++;
            end while (!fell && t < 4 * per);
            if (!fell) timeout("bit_fall");
            chk($sformatf("bit%0d_w%02h", i, w), TxOut, q[i]);
            if (i == inject_at) begin
                Valid = 1'b1;
                Din   = 8'h3C;
                step();
                Valid = 1'b0;
                chk("ready_while_busy", Ready, 1'b0);
                chk("busy_after_inject", Busy, 1'b1);
            end
            if (i == abort_at) return;
        end

        t = 0;
        while (Busy !== 1'b0 && t < 4 * per) begin
            step();
            t++;
        end
        if (Busy !== 1'b0) timeout("frame_end");
        chk("done_pulse", Done, 1'b1);
        chki("done_count", done_cnt, 1);
        chk("den_off", DivEnable, 1'b0);
        chk("ready_back", Ready, 1'b1);
        chk("idle_tx", TxOut, 1'b1);
    endtask

    initial begin
        logic [W-1:0] w;

        // Reset state
        step();
        step();
        chk("rst_tx", TxOut, 1'b1);
        chk("rst_ready", Ready, 1'b1);
        chk("rst_busy", Busy, 1'b0);
        chk("rst_den", DivEnable, 1'b0);
        chk("rst_done", Done, 1'b0);
        Reset = 1'b1;
        step();
        chk("post_rst_tx", TxOut, 1'b1);
        chk("post_rst_ready", Ready, 1'b1);

        // Directed A5 frame, DivClk period 8
        set_period(8);
        repeat (3) step();
        start_frame(8'hA5);
        rx_frame(8'hA5, -1, -1);
        repeat (3) step();
        chk("den_stays_low", DivEnable, 1'b0);

        // Valid pulse while busy is ignored
        start_frame(8'hA5);
        rx_frame(8'hA5, -1, 2);
        repeat (2 * per) step();
        chk("no_second_busy", Busy, 1'b0);
        chk("no_second_tx", TxOut, 1'b1);
        chki("no_second_done", done_cnt, 1);

        // Reset during data bit 3 aborts without Done
        start_frame(8'hA5);
        rx_frame(8'hA5, 3, -1);
        Reset    = 1'b0;
        done_cnt = 0;
        step();
        Reset = 1'b1;
        chk("abort_tx", TxOut, 1'b1);
        chk("abort_busy", Busy, 1'b0);
        chk("abort_den", DivEnable, 1'b0);
        chk("abort_ready", Ready, 1'b1);
        chk("abort_done", Done, 1'b0);
        repeat (2 * per) step();
        chki("abort_no_done", done_cnt, 0);
        start_frame(8'h01);
        rx_frame(8'h01, -1, -1);

        // Valid held high: back-to-back frames, one idle Clk between
        hold = 1;
        start_frame(8'hFF);
        Din = 8'h00;
        rx_frame(8'hFF, -1, -1);
        done_cnt = 0;
        step();
        hold  = 0;
        Valid = 1'b0;
        rx_frame(8'h00, -1, -1);

        // DivClk already high at accept: start bit holds until a real edge
        dforce = 1;
        repeat (3) step();
        start_frame(8'h5A);
        for (int i = 0; i < 12; i++) begin
            step();
            chk("start_hold", TxOut, 1'b0);
        end
        dforce = 0;
        dcnt   = 0;
        step();
        rx_frame(8'h5A, -1, -1);

        // Random words and divider periods
        for (int k = 0; k < 10; k++) begin
            set_period(4 + 2 * $urandom_range(0, 3));
            repeat ($urandom_range(0, 3)) step();
            w = W'($urandom);
            start_frame(w);
            rx_frame(w, -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
